fp_to_fixed_pipe: RTL and testbench

Converts IEEE-754 single-precision values into the team's sign-magnitude fixed-point format: sign bit, one integer bit and FRAC_W fraction bits, covering the range [-1, 1]. It is the return path of the fixed-to-float converter and sits between the float-side datapath and the fixed-point accelerator core. It is a 2-stage pipeline with valid/ready handshakes on both sides, saturation, and status flags.

---
 rtl/fp_fixed_pkg.sv | 34 +++
 rtl/fixed_shift_round.sv | 38 +++
 rtl/fp_to_fixed_pipe.sv | 151 +++++++++++++++
 tb/tb_fp_to_fixed_pipe.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_fixed_pkg.sv
// Shared definitions for the float<->fixed converters: IEEE-754 single
// constants, the input class enumeration and the stage-1 classifier.
package fp_fixed_pkg;

  localparam int EXP_BIAS = 127;
  localparam int MANT_W   = 23;

  localparam logic [31:0] FP_POS_ONE = 32'h3F800000;
  localparam logic [31:0] FP_NEG_ONE = 32'hBF800000;

  typedef enum logic [2:0] {
    ZERO,
    NAN,
    SAT,
    ONE,
    TINY,
    NORM
  } fp_class_e;

  // Exponents below EXP_BIAS-MANT_W push even the hidden bit far past the
  // rounding position of the 19-bit fraction, so they are grouped as TINY.
  function automatic fp_class_e classify(input logic [7:0] e, input logic [22:0] m);
    fp_class_e cls;
    if (e == 8'd0)                               cls = ZERO;
    else if (e == 8'd255 && m != '0)             cls = NAN;
    else if (e >= 8'(EXP_BIAS + 1))              cls = SAT;
    else if (e == 8'(EXP_BIAS) && m != '0)       cls = SAT;
    else if (e == 8'(EXP_BIAS))                  cls = ONE;
    else if (e < 8'(EXP_BIAS - MANT_W))          cls = TINY;
    else                                         cls = NORM;
    return cls;
  endfunction

endpackage

// File: rtl/fixed_shift_round.sv
// Stage-2 datapath: right-shifts the 24-bit significand into the
// {integer, fraction} magnitude. Optional macro FP_TO_FIXED_ROUND_EN adds
// round-to-nearest-even on the bits shifted out; without it the result is
// truncated toward zero.
module fixed_shift_round #(
  parameter int FRAC_W = 19
) (
  input  logic [23:0]       i_mant,
  input  logic [4:0]        i_sh,
  output logic [FRAC_W:0]   o_mag
);

  localparam int MAG_W = FRAC_W + 1;

`ifdef FP_TO_FIXED_ROUND_EN
  logic [55:0]      w_full;
  logic [MAG_W-1:0] w_trunc;
  logic             w_guard;
  logic             w_sticky;

  // Shift with 32 extension bits so the guard and sticky bits are kept;
  // the increment may carry into the integer bit, giving exactly 1.0.
  always_comb begin
    w_full   = {i_mant, 32'b0} >> i_sh;
    w_trunc  = MAG_W'(w_full[55:32]);
    w_guard  = w_full[31];
    w_sticky = |w_full[30:0];
    o_mag    = w_trunc + MAG_W'(w_guard & (w_sticky | w_trunc[0]));
  end
`else
  // Plain truncating shift; the significand's upper bits are always zero
  // after a shift of at least 5, so the cast drops nothing.
  always_comb begin
    o_mag = MAG_W'(i_mant >> i_sh);
  end
`endif

endmodule

// File: rtl/fp_to_fixed_pipe.sv
// IEEE-754 single to sign-magnitude fixed point {sign, integer, FRAC_W
// fraction bits}, range [-1, 1]. Two pipeline stages: unpack/classify, then
// shift/round/pack with saturation and status flags. Optional rounding is
// selected by the macro FP_TO_FIXED_ROUND_EN (see fixed_shift_round).
//
// Handshake: a word moves on any rising edge where its valid is high and
// the receiver's ready is high (valid_i&ready_o in, valid_o&ready_i out).
// A stage advances when it is empty or the stage after it advances, so
// ready_o is combinational and a full pipeline streams one word per cycle.
// While valid_o is high and ready_i low, every output holds.
module fp_to_fixed_pipe
  import fp_fixed_pkg::*;
#(
  parameter int FRAC_W = 19
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       fp_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              sign_o,
  output logic              integer_o,
  output logic [FRAC_W-1:0] fractional_o,
  output logic              sat_o,
  output logic              nan_o,
  output logic              underflow_o,
  output logic              valid_o,
  input  logic              ready_i
);

  localparam int MAG_W = FRAC_W + 1;
  localparam logic [MAG_W-1:0] MAG_ONE = {1'b1, {FRAC_W{1'b0}}};
  // Shift is only used for NORM, where it is 5..27, so modulo-32
  // arithmetic on the low exponent bits gives the exact value.
  localparam logic [4:0] SH_BASE = 5'(EXP_BIAS + MANT_W - FRAC_W);

  // Stage 1 registers
  logic        r_s1_valid;
  logic        r_s1_sign;
  logic [22:0] r_s1_man;
  logic [4:0]  r_s1_sh;
  fp_class_e   r_s1_cls;
  logic        r_s1_nz;

  // Stage 2 (output) registers
  logic             r_valid;
  logic             r_sign;
  logic [MAG_W-1:0] r_mag;
  logic             r_sat;
  logic             r_nan;
  logic             r_uf;

  logic             w_s2_adv;
  logic             w_s1_adv;
  fp_class_e        w_cls;
  logic [4:0]       w_sh;
  logic [MAG_W-1:0] w_norm_mag;
  logic [MAG_W-1:0] w_mag;
  logic             w_sign;
  logic             w_sat;
  logic             w_nan;
  logic             w_uf;

  assign w_s2_adv = ~r_valid | ready_i;
  assign w_s1_adv = ~r_s1_valid | w_s2_adv;
  assign ready_o  = w_s1_adv;

  assign w_cls = classify(fp_i[30:23], fp_i[22:0]);
  assign w_sh  = SH_BASE - fp_i[27:23];

  // Stage 1: capture sign, mantissa, shift amount and class.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_man   <= '0;
      r_s1_sh    <= '0;
      r_s1_cls   <= ZERO;
      r_s1_nz    <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= valid_i;
      if (valid_i) begin
        r_s1_sign <= fp_i[31];
        r_s1_man  <= fp_i[22:0];
        r_s1_sh   <= w_sh;
        r_s1_cls  <= w_cls;
        r_s1_nz   <= |fp_i[30:0];
      end
    end
  end

  fixed_shift_round #(
    .FRAC_W (FRAC_W)
  ) u_shift_round (
    .i_mant (({1'b1, r_s1_man})),
    .i_sh   (r_s1_sh),
    .o_mag  (w_norm_mag)
  );

  // Stage 2 result selection by class; a zero magnitude never carries a sign.
  always_comb begin
    w_mag = '0;
    w_sat = 1'b0;
    w_nan = 1'b0;
    w_uf  = 1'b0;
    case (r_s1_cls)
      NAN:  w_nan = 1'b1;
      SAT: begin
        w_mag = MAG_ONE;
        w_sat = 1'b1;
      end
      ONE:  w_mag = MAG_ONE;
      NORM: begin
        w_mag = w_norm_mag;
        w_uf  = (w_norm_mag == '0);
      end
      default: w_uf = r_s1_nz;
    endcase
    w_sign = r_s1_sign & (|w_mag);
  end

  // Stage 2: output register, held while downstream stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_sign  <= 1'b0;
      r_mag   <= '0;
      r_sat   <= 1'b0;
      r_nan   <= 1'b0;
      r_uf    <= 1'b0;
    end else if (w_s2_adv) begin
      r_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_sign <= w_sign;
        r_mag  <= w_mag;
        r_sat  <= w_sat;
        r_nan  <= w_nan;
        r_uf   <= w_uf;
      end
    end
  end

  assign valid_o      = r_valid;
  assign sign_o       = r_sign;
  assign integer_o    = r_mag[FRAC_W];
  assign fractional_o = r_mag[FRAC_W-1:0];
  assign sat_o        = r_sat;
  assign nan_o        = r_nan;
  assign underflow_o  = r_uf;

endmodule

// File: tb/tb_fp_to_fixed_pipe.sv
// Bench for fp_to_fixed_pipe: directed cases, backpressure, mid-stream
// reset and a randomized sweep, checked through an expected-value queue
// filled from an arithmetic reference model.
module tb_fp_to_fixed_pipe;
  import fp_fixed_pkg::*;

  localparam int FRAC_W = 19;
  localparam int W = 24; // {sign, integer, fraction, sat, nan, underflow}

  logic              clk_i;
  logic              rst_i;
  logic [31:0]       fp_i;
  logic              valid_i;
  logic              ready_o;
  logic              sign_o;
  logic              integer_o;
  logic [FRAC_W-1:0] fractional_o;
  logic              sat_o;
  logic              nan_o;
  logic              underflow_o;
  logic              valid_o;
  logic              ready_i;

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  bit rdy_rand = 0;

  fp_to_fixed_pipe #(.FRAC_W(FRAC_W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .fp_i         (fp_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .sign_o       (sign_o),
    .integer_o    (integer_o),
    .fractional_o (fractional_o),
    .sat_o        (sat_o),
    .nan_o        (nan_o),
    .underflow_o  (underflow_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i)
  );

  // ---------------- clock ----------------
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // ---------------- reference model ----------------
  // Fixed value = real value * 2^19 = (2^23 + m) * 2^(e-150+19).
  function automatic logic [W-1:0] ref_model(input logic [31:0] x);
    int     e;
    int     k;
    longint mant;
    longint q;
    longint rem;
    longint half;
    longint mag;
    logic   sat;
    logic   nan;
    logic   uf;
    e    = int'(x[30:23]);
    mant = longint'(x[22:0]);
    sat = 0; nan = 0; uf = 0; mag = 0;
    if (e == 255 && mant != 0) begin
      nan = 1;
    end else if (e == 255 || e > 127 || (e == 127 && mant != 0)) begin
      sat = 1;
      mag = longint'(1) << 19;
    end else if (e == 0) begin
      uf = (mant != 0);
    end else begin
      mant = mant + (longint'(1) << 23);
      k = 150 - FRAC_W - e;
      if (k >= 62) begin
        q = 0;
      end else begin
        q   = mant >> k;
        rem = mant - (q << k);
`ifdef FP_TO_FIXED_ROUND_EN
        half = longint'(1) << (k - 1);
        if (rem > half || (rem == half && q[0]))
          q = q + 1;
`else
        half = 0;
        if (rem < half) q = 0;
`endif
      end
      mag = q;
      uf  = (mag == 0);
    end
    return {x[31] && (mag != 0), 20'(mag), sat, nan, uf};
  endfunction

  function automatic logic [W-1:0] dut_word();
    return {sign_o, integer_o, fractional_o, sat_o, nan_o, underflow_o};
  endfunction

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- input monitor: push expected on accept ----------------
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i && valid_i && ready_o)
        exp_q.push_back(ref_model(fp_i));
    end
  end

  // ---------------- output monitor: pop and compare, check stall hold -----
  initial begin
    logic [W-1:0] held;
    logic [W-1:0] exp_w;
    bit hold_pending;
    hold_pending = 0;
    held = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        hold_pending = 0;
      end else begin
        if (hold_pending) begin
          n_tests++;
          if (!(valid_o && dut_word() == held)) begin
            n_fail++;
            $display("FAIL stall_hold: got valid=%0b word=%h expected valid=1 word=%h at %0t",
                     valid_o, dut_word(), held, $time);
          end
        end
        if (valid_o && ready_i) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: got word=%h expected no output at %0t", dut_word(), $time);
          end else begin
            exp_w = exp_q.pop_front();
            if (dut_word() !== exp_w) begin
              n_fail++;
              $display("FAIL result: got %h expected %h (sign,int,frac,sat,nan,uf) at %0t",
                       dut_word(), exp_w, $time);
            end
          end
        end
        hold_pending = valid_o && !ready_i;
        held = dut_word();
      end
    end
  end

  // ---------------- ready_i randomizer ----------------
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (rdy_rand) ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] x);
    bit acc;
    int guard;
    acc = 0;
    guard = 0;
    fp_i = x;
    valid_i = 1'b1;
    while (!acc && guard < 200) begin
      @(negedge clk_i);
      acc = ready_o;
      @(posedge clk_i);
      #1;
      guard++;
    end
    valid_i = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got no accept expected accept within 200 cycles for %h", x);
    end
  endtask

  task automatic drain();
    int guard;
    rdy_rand = 0;
    ready_i = 1'b1;
    guard = 0;
    while ((exp_q.size() != 0 || valid_o) && guard < 50) begin
      @(posedge clk_i);
      #1;
      guard++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
    end
  endtask

  function automatic logic [31:0] rand_fp();
    logic [31:0] specials[10];
    logic [31:0] x;
    int sel;
    specials = '{32'h00000000, 32'h80000000, FP_POS_ONE, FP_NEG_ONE, 32'h7F800000,
                 32'hFF800000, 32'h7FC00000, 32'h00000001, 32'h3F7FFFFF, 32'hB5800000};
    sel = $urandom_range(0, 9);
    x = $urandom;
    if (sel < 2) begin
      // fully random bits
    end else if (sel < 7) begin
      x[30:23] = 8'($urandom_range(100, 129));
    end else if (sel == 7) begin
      x = specials[$urandom_range(0, 9)];
    end else if (sel == 8) begin
      x[30:23] = 8'd107;
      x[22:0]  = ($urandom_range(0, 1) == 0) ? 23'd0 : 23'($urandom_range(0, 3));
    end else begin
      x[30:23] = 8'd126;
      x[22:0]  = 23'h7FFFFF - 23'($urandom_range(0, 40));
    end
    return x;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] directed[12];
    directed = '{32'h3F000000, 32'hBF800000, 32'h3F800001, 32'hFF800000,
                 32'h7FC00000, 32'h80000000, 32'h3F7FFFFF, 32'h35800000,
                 32'h35800001, 32'h00000001, 32'h33000000, 32'h7F800000};
    rst_i = 1'b1;
    fp_i = '0;
    valid_i = 1'b0;
    ready_i = 1'b1;

    // reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_valid_o", 32'(valid_o), 32'd0);
    check("reset_ready_o", 32'(ready_o), 32'd1);
    check("reset_outputs", 32'(dut_word()), 32'd0);
    #2 rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // directed values, streaming
    foreach (directed[i]) send(directed[i]);
    drain();

    // backpressure: 4 back-to-back, ready_i low for 3 cycles
    ready_i = 1'b0;
    fork
      begin
        send(32'h3E800000);
        send(32'hBF400000);
        send(32'h3F7FFFFF);
        send(32'h7FC00001);
      end
      begin
        repeat (3) @(posedge clk_i);
        #1;
        check("bp_ready_o_full", 32'(ready_o), 32'd0);
        check("bp_valid_o_held", 32'(valid_o), 32'd1);
        ready_i = 1'b1;
      end
    join
    drain();

    // reset with two items in flight
    send(32'h3F200000);
    send(32'hBE000000);
    #2 rst_i = 1'b1;
    #1;
    check("midrst_valid_o", 32'(valid_o), 32'd0);
    check("midrst_outputs", 32'(dut_word()), 32'd0);
    check("midrst_ready_o", 32'(ready_o), 32'd1);
    exp_q.delete();
    @(negedge clk_i);
    #1 rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    send(32'hBF000000);
    check("lat_edge1_valid_o", 32'(valid_o), 32'd0);
    @(posedge clk_i);
    #1;
    check("lat_edge2_valid_o", 32'(valid_o), 32'd1);
    drain();

    // randomized sweep with random valid gaps and random ready_i
    rdy_rand = 1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk_i);
        #1;
      end
      send(rand_fp());
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before 2 ms");
    $fatal(1, "timeout");
  end

endmodule
